// File: rtl/rv_decode_stage_if.sv
// Handshake and decoded-instruction bus for the RV32I decode stage.
// master: fetch/consumer side (drives in_*, flush, out_ready).
// slave:  decode stage (drives in_ready and all out_* fields).
interface rv_decode_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_op;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic [WIDTH-1:0] out_imm;
    logic [4:0]       out_shamt;
    logic [31:0]      out_pc;
    logic             out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd,
               out_imm, out_shamt, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd,
               out_imm, out_shamt, out_pc, out_illegal
    );
endinterface

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: decodes raw instruction words into op code, register
// indices, sign-extended immediate and shift amount, behind a two-entry skid
// buffer so one instruction per cycle is sustained under backpressure.
// Ports: clk, rst (async, active-high), bus (rv_decode_stage_if.slave):
//   in_valid/in_ready/in_instr/in_pc/flush from fetch,
//   out_valid/out_ready/out_op/out_rs1/out_rs2/out_rd/out_imm/out_shamt/
//   out_pc/out_illegal to the ALU / register file.
module rv_decode_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    rv_decode_stage_if.slave    bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 6;
    localparam int unsigned RW   = 5;

    typedef enum logic [OPW-1:0] {
        OP_NONE  = 6'd0,  OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,  OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,  OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10, OP_LB    = 6'd11,
        OP_LH    = 6'd12, OP_LW    = 6'd13, OP_LBU   = 6'd14, OP_LHU   = 6'd15,
        OP_SB    = 6'd16, OP_SH    = 6'd17, OP_SW    = 6'd18, OP_ADDI  = 6'd19,
        OP_SLTI  = 6'd20, OP_SLTIU = 6'd21, OP_XORI  = 6'd22, OP_ORI   = 6'd23,
        OP_ANDI  = 6'd24, OP_SLLI  = 6'd25, OP_SRLI  = 6'd26, OP_SRAI  = 6'd27,
        OP_ADD   = 6'd28, OP_SUB   = 6'd29, OP_SLL   = 6'd30, OP_SLT   = 6'd31,
        OP_SLTU  = 6'd32, OP_XOR   = 6'd33, OP_SRL   = 6'd34, OP_SRA   = 6'd35,
        OP_OR    = 6'd36, OP_AND   = 6'd37
    } op_e;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    typedef enum logic [1:0] {
        EMPTY, ONE, TWO
    } state_e;

    typedef struct packed {
        logic [OPW-1:0]   op;
        logic [RW-1:0]    rs1;
        logic [RW-1:0]    rs2;
        logic [RW-1:0]    rd;
        logic [WIDTH-1:0] imm;
        logic [RW-1:0]    shamt;
        logic [XLEN-1:0]  pc;
        logic             illegal;
    } dec_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [XLEN-1:0] instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    op_e    op;
    fmt_e   fmt;
    dec_t   dec;
    dec_t   main_q;
    dec_t   skid_q;
    state_e state;
    logic   out_valid_q;
    logic   in_ready_q;
    logic   acc;
    logic   take;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Raw RV32I immediates, already sign-extended from bit 31 to 32 bits
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Operation and format selection from opcode/funct3/funct7
    always_comb begin
        op  = OP_NONE;
        fmt = FMT_R;
        case (opcode)
            OPC_LUI:   begin op = OP_LUI;   fmt = FMT_U; end
            OPC_AUIPC: begin op = OP_AUIPC; fmt = FMT_U; end
            OPC_JAL:   begin op = OP_JAL;   fmt = FMT_J; end
            OPC_JALR: begin
                fmt = FMT_I;
                if (funct3 == 3'b000) op = OP_JALR;
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                case (funct3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: op = OP_NONE;
                endcase
            end
            OPC_LOAD: begin
                fmt = FMT_I;
                case (funct3)
                    3'b000:  op = OP_LB;
                    3'b001:  op = OP_LH;
                    3'b010:  op = OP_LW;
                    3'b100:  op = OP_LBU;
                    3'b101:  op = OP_LHU;
                    default: op = OP_NONE;
                endcase
            end
            OPC_STORE: begin
                fmt = FMT_S;
                case (funct3)
                    3'b000:  op = OP_SB;
                    3'b001:  op = OP_SH;
                    3'b010:  op = OP_SW;
                    default: op = OP_NONE;
                endcase
            end
            OPC_OPIMM: begin
                fmt = FMT_I;
                case (funct3)
                    3'b000: op = OP_ADDI;
                    3'b010: op = OP_SLTI;
                    3'b011: op = OP_SLTIU;
                    3'b100: op = OP_XORI;
                    3'b110: op = OP_ORI;
                    3'b111: op = OP_ANDI;
                    3'b001: begin
                        fmt = FMT_ISH;
                        if (funct7 == F7_BASE) op = OP_SLLI;
                    end
                    3'b101: begin
                        fmt = FMT_ISH;
                        if (funct7 == F7_BASE)     op = OP_SRLI;
                        else if (funct7 == F7_ALT) op = OP_SRAI;
                    end
                    default: op = OP_NONE;
                endcase
            end
            OPC_OP: begin
                fmt = FMT_R;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: op = OP_ADD;
                    {F7_ALT,  3'b000}: op = OP_SUB;
                    {F7_BASE, 3'b001}: op = OP_SLL;
                    {F7_BASE, 3'b010}: op = OP_SLT;
                    {F7_BASE, 3'b011}: op = OP_SLTU;
                    {F7_BASE, 3'b100}: op = OP_XOR;
                    {F7_BASE, 3'b101}: op = OP_SRL;
                    {F7_ALT,  3'b101}: op = OP_SRA;
                    {F7_BASE, 3'b110}: op = OP_OR;
                    {F7_BASE, 3'b111}: op = OP_AND;
                    default:           op = OP_NONE;
                endcase
            end
            default: op = OP_NONE;
        endcase
    end

    // Field assembly; fields absent from the format (or an illegal word) stay 0
    always_comb begin
        dec    = '0;
        dec.pc = bus.in_pc;
        if (op == OP_NONE) begin
            dec.illegal = 1'b1;
        end else begin
            dec.op = op;
            case (fmt)
                FMT_R: begin
                    dec.rs1 = instr[19:15];
                    dec.rs2 = instr[24:20];
                    dec.rd  = instr[11:7];
                end
                FMT_I, FMT_ISH: begin
                    dec.rs1 = instr[19:15];
                    dec.rd  = instr[11:7];
                    dec.imm = WIDTH'($signed(imm_i));
                    if (fmt == FMT_ISH) dec.shamt = instr[24:20];
                end
                FMT_S: begin
                    dec.rs1 = instr[19:15];
                    dec.rs2 = instr[24:20];
                    dec.imm = WIDTH'($signed(imm_s));
                end
                FMT_B: begin
                    dec.rs1 = instr[19:15];
                    dec.rs2 = instr[24:20];
                    dec.imm = WIDTH'($signed(imm_b));
                end
                FMT_U: begin
                    dec.rd  = instr[11:7];
                    dec.imm = WIDTH'($signed(imm_u));
                end
                FMT_J: begin
                    dec.rd  = instr[11:7];
                    dec.imm = WIDTH'($signed(imm_j));
                end
                default: dec = '0;
            endcase
        end
    end

    assign acc  = bus.in_valid & in_ready_q;
    assign take = out_valid_q & bus.out_ready;

    // Skid-buffer FSM; out_valid/in_ready are registered decodes of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (bus.flush) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        main_q      <= dec;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (acc && !take) begin
                        skid_q     <= dec;
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (acc && take) begin
                        main_q <= dec;
                    end else if (take) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (take) begin
                        main_q     <= skid_q;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_op      = main_q.op;
    assign bus.out_rs1     = main_q.rs1;
    assign bus.out_rs2     = main_q.rs2;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_shamt   = main_q.shamt;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_illegal = main_q.illegal;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Testbench for rv_decode_stage: directed vectors, a reference decoder built
// from an RV32I encoding table, and a queue model of the two-entry buffer.
module tb_rv_decode_stage;
    localparam int unsigned WIDTH = 32;

    localparam int F_NONE = 0, F_R = 1, F_I = 2, F_SH = 3, F_S = 4, F_B = 5, F_U = 6, F_J = 7;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [31:0] pc;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    rv_decode_stage_if #(.WIDTH(WIDTH)) bus ();

    rv_decode_stage #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder: one table row per RV32I encoding
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int   op;
        int   fmt;
        e   = '{op: '0, rs1: '0, rs2: '0, rd: '0, imm: '0, shamt: '0, pc: pc, illegal: 1'b0};
        op  = 0;
        fmt = F_NONE;
        casez (w)
            32'b???????_?????_?????_???_?????_0110111: begin op = 1;  fmt = F_U;  end
            32'b???????_?????_?????_???_?????_0010111: begin op = 2;  fmt = F_U;  end
            32'b???????_?????_?????_???_?????_1101111: begin op = 3;  fmt = F_J;  end
            32'b???????_?????_?????_000_?????_1100111: begin op = 4;  fmt = F_I;  end
            32'b???????_?????_?????_000_?????_1100011: begin op = 5;  fmt = F_B;  end
            32'b???????_?????_?????_001_?????_1100011: begin op = 6;  fmt = F_B;  end
            32'b???????_?????_?????_100_?????_1100011: begin op = 7;  fmt = F_B;  end
            32'b???????_?????_?????_101_?????_1100011: begin op = 8;  fmt = F_B;  end
            32'b???????_?????_?????_110_?????_1100011: begin op = 9;  fmt = F_B;  end
            32'b???????_?????_?????_111_?????_1100011: begin op = 10; fmt = F_B;  end
            32'b???????_?????_?????_000_?????_0000011: begin op = 11; fmt = F_I;  end
            32'b???????_?????_?????_001_?????_0000011: begin op = 12; fmt = F_I;  end
            32'b???????_?????_?????_010_?????_0000011: begin op = 13; fmt = F_I;  end
            32'b???????_?????_?????_100_?????_0000011: begin op = 14; fmt = F_I;  end
            32'b???????_?????_?????_101_?????_0000011: begin op = 15; fmt = F_I;  end
            32'b???????_?????_?????_000_?????_0100011: begin op = 16; fmt = F_S;  end
            32'b???????_?????_?????_001_?????_0100011: begin op = 17; fmt = F_S;  end
            32'b???????_?????_?????_010_?????_0100011: begin op = 18; fmt = F_S;  end
            32'b???????_?????_?????_000_?????_0010011: begin op = 19; fmt = F_I;  end
            32'b???????_?????_?????_010_?????_0010011: begin op = 20; fmt = F_I;  end
            32'b???????_?????_?????_011_?????_0010011: begin op = 21; fmt = F_I;  end
            32'b???????_?????_?????_100_?????_0010011: begin op = 22; fmt = F_I;  end
            32'b???????_?????_?????_110_?????_0010011: begin op = 23; fmt = F_I;  end
            32'b???????_?????_?????_111_?????_0010011: begin op = 24; fmt = F_I;  end
            32'b0000000_?????_?????_001_?????_0010011: begin op = 25; fmt = F_SH; end
            32'b0000000_?????_?????_101_?????_0010011: begin op = 26; fmt = F_SH; end
            32'b0100000_?????_?????_101_?????_0010011: begin op = 27; fmt = F_SH; end
            32'b0000000_?????_?????_000_?????_0110011: begin op = 28; fmt = F_R;  end
            32'b0100000_?????_?????_000_?????_0110011: begin op = 29; fmt = F_R;  end
            32'b0000000_?????_?????_001_?????_0110011: begin op = 30; fmt = F_R;  end
            32'b0000000_?????_?????_010_?????_0110011: begin op = 31; fmt = F_R;  end
            32'b0000000_?????_?????_011_?????_0110011: begin op = 32; fmt = F_R;  end
            32'b0000000_?????_?????_100_?????_0110011: begin op = 33; fmt = F_R;  end
            32'b0000000_?????_?????_101_?????_0110011: begin op = 34; fmt = F_R;  end
            32'b0100000_?????_?????_101_?????_0110011: begin op = 35; fmt = F_R;  end
            32'b0000000_?????_?????_110_?????_0110011: begin op = 36; fmt = F_R;  end
            32'b0000000_?????_?????_111_?????_0110011: begin op = 37; fmt = F_R;  end
            default: begin op = 0; fmt = F_NONE; end
        endcase
        e.op = 6'(op);
        if (op == 0) e.illegal = 1'b1;
        if (fmt == F_R || fmt == F_I || fmt == F_SH || fmt == F_S || fmt == F_B) e.rs1 = w[19:15];
        if (fmt == F_R || fmt == F_S || fmt == F_B) e.rs2 = w[24:20];
        if (fmt == F_R || fmt == F_I || fmt == F_SH || fmt == F_U || fmt == F_J) e.rd = w[11:7];
        if (fmt == F_SH) e.shamt = w[24:20];
        if (fmt == F_I || fmt == F_SH) e.imm = {{20{w[31]}}, w[31:20]};
        if (fmt == F_S) e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
        if (fmt == F_B) e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        if (fmt == F_U) e.imm = {w[31:12], 12'h000};
        if (fmt == F_J) e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        return e;
    endfunction

    // Per-cycle compare against the queue model; updates follow the checks
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            automatic logic model_ready = (q.size() < 2);
            chk("in_ready", 64'(bus.in_ready), 64'(model_ready));
            chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
            if (bus.out_valid && q.size() != 0) begin
                chk("op",      64'(bus.out_op),      64'(q[0].op));
                chk("rs1",     64'(bus.out_rs1),     64'(q[0].rs1));
                chk("rs2",     64'(bus.out_rs2),     64'(q[0].rs2));
                chk("rd",      64'(bus.out_rd),      64'(q[0].rd));
                chk("imm",     64'(bus.out_imm),     64'(q[0].imm));
                chk("shamt",   64'(bus.out_shamt),   64'(q[0].shamt));
                chk("pc",      64'(bus.out_pc),      64'(q[0].pc));
                chk("illegal", 64'(bus.out_illegal), 64'(q[0].illegal));
                if (bus.out_ready) void'(q.pop_front());
            end
            if (bus.flush) q.delete();
            else if (bus.in_valid && model_ready) q.push_back(model(bus.in_instr, bus.in_pc));
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and wait (bounded) until it is accepted
    task automatic send(input logic [31:0] w, input logic [31:0] pc, input bit rnd);
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        bus.in_pc    = pc;
        for (int i = 0; i < 60; i++) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_ready) begin
                sync();
                bus.in_valid = 1'b0;
                return;
            end
            sync();
        end
        chk("send_timeout", 64'(0), 64'(1));
        bus.in_valid = 1'b0;
    endtask

    logic [31:0] vec [10];

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
        chk("rst_op",        64'(bus.out_op),    64'(0));
        chk("rst_illegal",   64'(bus.out_illegal), 64'(0));
        chk("rst_imm",       64'(bus.out_imm),   64'(0));
        @(negedge clk);
        #1 rst = 1'b0;
        sync();

        // addi x1,x2,-1
        bus.out_ready = 1'b1;
        send(32'hFFF10093, 32'h0000_0100, 1'b0);
        @(negedge clk);
        chk("addi_valid", 64'(bus.out_valid), 64'(1));
        chk("addi_op",    64'(bus.out_op),    64'(19));
        chk("addi_rs1",   64'(bus.out_rs1),   64'(2));
        chk("addi_rs2",   64'(bus.out_rs2),   64'(0));
        chk("addi_rd",    64'(bus.out_rd),    64'(1));
        chk("addi_imm",   64'(bus.out_imm),   64'(32'hFFFF_FFFF));
        chk("addi_ill",   64'(bus.out_illegal), 64'(0));
        sync();

        // sub x3,x1,x2 then beq x1,x2,-4
        send(32'h402081B3, 32'h0000_0104, 1'b0);
        @(negedge clk);
        chk("sub_op",  64'(bus.out_op),  64'(29));
        chk("sub_rs1", 64'(bus.out_rs1), 64'(1));
        chk("sub_rs2", 64'(bus.out_rs2), 64'(2));
        chk("sub_rd",  64'(bus.out_rd),  64'(3));
        chk("sub_imm", 64'(bus.out_imm), 64'(0));
        sync();
        send(32'hFE208EE3, 32'h0000_0108, 1'b0);
        @(negedge clk);
        chk("beq_op",  64'(bus.out_op),  64'(5));
        chk("beq_rs1", 64'(bus.out_rs1), 64'(1));
        chk("beq_rs2", 64'(bus.out_rs2), 64'(2));
        chk("beq_rd",  64'(bus.out_rd),  64'(0));
        chk("beq_imm", 64'(bus.out_imm), 64'(32'hFFFF_FFFC));
        sync();

        // lui x5,0x12345 then srai x3,x2,5
        send(32'h123452B7, 32'h0000_010C, 1'b0);
        @(negedge clk);
        chk("lui_op",  64'(bus.out_op),  64'(1));
        chk("lui_rd",  64'(bus.out_rd),  64'(5));
        chk("lui_rs1", 64'(bus.out_rs1), 64'(0));
        chk("lui_imm", 64'(bus.out_imm), 64'(32'h1234_5000));
        sync();
        send(32'h40515193, 32'h0000_0110, 1'b0);
        @(negedge clk);
        chk("srai_op",    64'(bus.out_op),    64'(27));
        chk("srai_shamt", 64'(bus.out_shamt), 64'(5));
        chk("srai_rs1",   64'(bus.out_rs1),   64'(2));
        chk("srai_rd",    64'(bus.out_rd),    64'(3));
        sync();
        repeat (2) sync();

        // Backpressure: A=add x5,x6,x7, B=sw x2,8(x1), C=jal x1,16
        bus.out_ready = 1'b0;
        send(32'h007302B3, 32'h0000_0200, 1'b0);
        send(32'h0020A423, 32'h0000_0204, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h010000EF;
        bus.in_pc    = 32'h0000_0208;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_in_ready", 64'(bus.in_ready), 64'(0));
            chk("hold_op",       64'(bus.out_op),   64'(28));
            chk("hold_rd",       64'(bus.out_rd),   64'(5));
            sync();
        end
        bus.out_ready = 1'b1;
        send(32'h010000EF, 32'h0000_0208, 1'b0);
        repeat (4) sync();
        @(negedge clk);
        chk("drain_valid", 64'(bus.out_valid), 64'(0));
        sync();

        // Flush in TWO with word D offered
        bus.out_ready = 1'b0;
        send(32'h00C50513, 32'h0000_0300, 1'b0);
        send(32'h00B50533, 32'h0000_0304, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00100093;
        bus.in_pc    = 32'h0000_0DDD;
        bus.flush    = 1'b1;
        sync();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush2_valid", 64'(bus.out_valid), 64'(0));
        chk("flush2_ready", 64'(bus.in_ready),  64'(1));
        sync();

        // Flush in ONE while in_ready=1: D still not stored
        send(32'h00C50513, 32'h0000_0310, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00100093;
        bus.in_pc    = 32'h0000_0DDD;
        bus.flush    = 1'b1;
        sync();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush1_valid", 64'(bus.out_valid), 64'(0));
        sync();
        repeat (2) sync();

        // Illegal words still complete the handshake
        bus.out_ready = 1'b1;
        send(32'h0000_0000, 32'h0000_0400, 1'b0);
        @(negedge clk);
        chk("ill_valid", 64'(bus.out_valid),   64'(1));
        chk("ill_op",    64'(bus.out_op),      64'(0));
        chk("ill_flag",  64'(bus.out_illegal), 64'(1));
        chk("ill_pc",    64'(bus.out_pc),      64'(32'h0000_0400));
        chk("ill_imm",   64'(bus.out_imm),     64'(0));
        sync();
        send(32'h02208033, 32'h0000_0404, 1'b0);
        send(32'h40209093, 32'h0000_0408, 1'b0);

        // Mixed formats under random backpressure
        vec[0] = 32'h0080A183;  // lw x3,8(x1)
        vec[1] = 32'hFFF14203;  // lbu x4,-1(x2)
        vec[2] = 32'h0020F463;  // bgeu x1,x2,8
        vec[3] = 32'hFFFFF317;  // auipc x6,0xFFFFF
        vec[4] = 32'h004080E7;  // jalr x1,4(x1)
        vec[5] = 32'h0030D393;  // srli x7,x1,3
        vec[6] = 32'h0FF13413;  // sltiu x8,x2,255
        vec[7] = 32'h4020D4B3;  // sra x9,x1,x2
        vec[8] = 32'h80000A6F;  // jal x20,-1M
        vec[9] = 32'hFE112E23;  // sw x1,-4(x2)
        for (int i = 0; i < 10; i++) send(vec[i], 32'h0000_0500 + 32'(4 * i), 1'b1);
        bus.out_ready = 1'b1;
        repeat (4) sync();

        // Async reset while holding one word
        bus.out_ready = 1'b0;
        send(32'h00C50513, 32'h0000_0600, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'(0));
        chk("arst_ready", 64'(bus.in_ready),  64'(1));
        @(negedge clk);
        #1 rst = 1'b0;
        sync();
        bus.out_ready = 1'b1;
        send(32'h00A00293, 32'h0000_0700, 1'b0);
        @(negedge clk);
        chk("post_rst_op", 64'(bus.out_op), 64'(19));
        chk("post_rst_imm", 64'(bus.out_imm), 64'(10));
        repeat (3) sync();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
